// File: rtl/mt_pc_sched.sv
// mt_pc_sched: per-thread PC file with round-robin thread selection for fetch.
// Optional feature macro: MT_PC_START_VEC_EN (per-thread reset start vectors
// RESET_BASE + i*RESET_STRIDE; when undefined every thread resets to PC 0).
module mt_pc_sched #(
  parameter int unsigned NUM_THREADS   = 8,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter logic [NUM_THREADS-1:0]   INIT_ACTIVE  = {NUM_THREADS{1'b1}},
  parameter logic [ADDRESS_WIDTH-1:0] RESET_BASE   = '0,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_STRIDE = ADDRESS_WIDTH'(32'h100)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_ready,
  output logic                             fetch_valid,
  output logic [$clog2(NUM_THREADS)-1:0]   fetch_tid,
  output logic [ADDRESS_WIDTH-1:0]         fetch_pc,
  output logic [ADDRESS_WIDTH-1:0]         fetch_pc_plus4,
  input  logic                             redirect_valid,
  input  logic [$clog2(NUM_THREADS)-1:0]   redirect_tid,
  input  logic [ADDRESS_WIDTH-1:0]         redirect_pc,
  input  logic                             spawn_valid,
  input  logic [$clog2(NUM_THREADS)-1:0]   spawn_tid,
  input  logic [ADDRESS_WIDTH-1:0]         spawn_pc,
  input  logic                             kill_valid,
  input  logic [$clog2(NUM_THREADS)-1:0]   kill_tid,
  output logic [NUM_THREADS-1:0]           active_mask
);

  localparam int unsigned TB = $clog2(NUM_THREADS);

  logic [ADDRESS_WIDTH-1:0] r_pc [NUM_THREADS];
  logic [NUM_THREADS-1:0]   r_active;
  logic [TB-1:0]            r_rr_ptr;

  logic [TB-1:0] w_sel;
  logic [TB-1:0] w_idx;
  logic          w_found;
  logic          w_fire;

  // Reset PC for thread idx.
  function automatic logic [ADDRESS_WIDTH-1:0] start_vec(input int unsigned idx);
`ifdef MT_PC_START_VEC_EN
    return ADDRESS_WIDTH'(RESET_BASE + ADDRESS_WIDTH'(idx) * RESET_STRIDE);
`else
    return ADDRESS_WIDTH'(idx & 32'd0);
`endif
  endfunction

`ifndef MT_PC_START_VEC_EN
  // Start-vector parameters have no effect in this build.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{RESET_BASE, RESET_STRIDE};
`endif

  // Round-robin search: first active thread at or after r_rr_ptr.
  always_comb begin
    w_sel   = r_rr_ptr;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      w_idx = r_rr_ptr + TB'(i);
      if (!w_found && r_active[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign fetch_valid    = (|r_active) & ~rst;
  assign fetch_tid      = fetch_valid ? w_sel : r_rr_ptr;
  assign fetch_pc       = r_pc[fetch_tid];
  assign fetch_pc_plus4 = fetch_pc + ADDRESS_WIDTH'(4);
  assign active_mask    = r_active;
  assign w_fire         = fetch_valid & fetch_ready;

  // State update; later assignments win, giving spawn > redirect > fire on PC
  // and kill > spawn on the active bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= INIT_ACTIVE;
      r_rr_ptr <= '0;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        r_pc[i] <= start_vec(i);
      end
    end else begin
      if (w_fire) begin
        r_pc[fetch_tid] <= fetch_pc_plus4;
        r_rr_ptr        <= fetch_tid + TB'(1);
      end
      if (redirect_valid) begin
        r_pc[redirect_tid] <= redirect_pc;
      end
      if (spawn_valid) begin
        r_pc[spawn_tid]     <= spawn_pc;
        r_active[spawn_tid] <= 1'b1;
      end
      if (kill_valid) begin
        r_active[kill_tid] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mt_pc_sched.sv
// tb_mt_pc_sched: directed plus randomized checks of mt_pc_sched against a
// reference model of per-thread PCs, run states and round-robin pointer.
module tb_mt_pc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [2:0]  fetch_tid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_plus4;
  logic        redirect_valid;
  logic [2:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic        spawn_valid;
  logic [2:0]  spawn_tid;
  logic [31:0] spawn_pc;
  logic        kill_valid;
  logic [2:0]  kill_tid;
  logic [7:0]  active_mask;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc [8];
  logic [7:0]  m_act;
  int          m_rr;

  mt_pc_sched #(
    .NUM_THREADS(8), .ADDRESS_WIDTH(32), .INIT_ACTIVE(8'hFF),
    .RESET_BASE(32'h1000), .RESET_STRIDE(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_tid(fetch_tid), .fetch_pc(fetch_pc),
    .fetch_pc_plus4(fetch_pc_plus4),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
    .spawn_valid(spawn_valid), .spawn_tid(spawn_tid), .spawn_pc(spawn_pc),
    .kill_valid(kill_valid), .kill_tid(kill_tid), .active_mask(active_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sv(input int i);
`ifdef MT_PC_START_VEC_EN
    return 32'h1000 + 32'h100 * i;
`else
    return 32'h0 + 32'(i) * 32'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance model.
  task automatic cycle(input bit chk_en, input bit r, input bit rdy,
                       input bit rv, input int rt, input logic [31:0] rp,
                       input bit sp, input int st, input logic [31:0] spc,
                       input bit kv, input int kt);
    bit ev;
    int et;
    rst = r; fetch_ready = rdy;
    redirect_valid = rv; redirect_tid = 3'(rt); redirect_pc = rp;
    spawn_valid = sp; spawn_tid = 3'(st); spawn_pc = spc;
    kill_valid = kv; kill_tid = 3'(kt);
    #1;
    ev = (m_act != 8'h0) && !r;
    et = m_rr;
    if (ev) begin
      for (int off = 7; off >= 0; off--)
        if (m_act[(m_rr + off) % 8]) et = (m_rr + off) % 8;
    end
    if (chk_en) begin
      chk("valid", 32'(fetch_valid), 32'(ev));
      chk("tid", 32'(fetch_tid), 32'(et));
      chk("pc", fetch_pc, m_pc[et]);
      chk("pc_plus4", fetch_pc_plus4, m_pc[et] + 32'd4);
      chk("active_mask", 32'(active_mask), 32'(m_act));
    end
    @(posedge clk);
    if (r) begin
      m_act = 8'hFF;
      m_rr  = 0;
      for (int i = 0; i < 8; i++) m_pc[i] = sv(i);
    end else begin
      if (ev && rdy) begin
        m_pc[et] = m_pc[et] + 32'd4;
        m_rr     = (et + 1) % 8;
      end
      if (rv) m_pc[rt] = rp;
      if (sp) begin m_pc[st] = spc; m_act[st] = 1'b1; end
      if (kv) m_act[kt] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cycle(1, 0, rdy, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_act = 8'h0; m_rr = 0;
    for (int i = 0; i < 8; i++) m_pc[i] = 32'h0;
    // Reset
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 2, 32'h55, 1, 3, 32'h66, 1, 4);
    chk("reset_mask", 32'(active_mask), 32'hFF);
    // Full rotation twice
    for (int i = 0; i < 16; i++) idle(1);
    chk("rotate_mask", 32'(active_mask), 32'hFF);
    chk("rotate_pc0", fetch_pc, sv(0) + 32'h8);
    // Kill 1..6 then alternate 0,7
    for (int t = 1; t <= 6; t++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, t);
    chk("kill_mask", 32'(active_mask), 32'h81);
    for (int i = 0; i < 4; i++) idle(1);
    // Only thread 3 runnable
    cycle(1, 0, 0, 0, 0, 0, 1, 3, 32'h300, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    chk("only3_tid", 32'(fetch_tid), 32'd3);
    cycle(1, 0, 1, 1, 3, 32'h400, 0, 0, 0, 0, 0);
    chk("redir_over_fire", fetch_pc, 32'h400);
    cycle(1, 0, 1, 1, 3, 32'h500, 1, 3, 32'h800, 0, 0);
    chk("spawn_over_redir", fetch_pc, 32'h800);
    // Fire and kill same thread -> nothing active
    cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3);
    chk("all_killed_valid", 32'(fetch_valid), 32'd0);
    idle(1);
    idle(1);
    cycle(1, 0, 1, 0, 0, 0, 1, 5, 32'h1000, 0, 0);
    chk("spawn5_tid", 32'(fetch_tid), 32'd5);
    chk("spawn5_pc", fetch_pc, 32'h1000);
    idle(1);
    chk("spawn5_pc_next", fetch_pc, 32'h1004);
    for (int i = 0; i < 4; i++) idle(0);
    chk("stall_pc", fetch_pc, 32'h1004);
    cycle(1, 0, 0, 1, 5, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    chk("wrap_plus4", fetch_pc_plus4, 32'h0);
    idle(1);
    chk("wrap_pc", fetch_pc, 32'h0);
    // Reset mid-operation with every input asserted
    cycle(1, 1, 1, 1, 5, 32'h77, 1, 2, 32'h88, 1, 0);
    chk("midrst_mask", 32'(active_mask), 32'hFF);
    chk("midrst_tid", 32'(fetch_tid), 32'd0);
    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4)
                                       : ($urandom & 32'hFFFF_FFFC);
      cycle(1, $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)), rp,
            $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
